gtp_rx_deframer: RTL and testbench
==================================

Name: gtp_rx_deframer

Overview:
- Receive-side counterpart of the GTP link transmitter. The transmitter sends IDLE words while its FIFO is empty and data words otherwise.
- Sits between the GTP RX user interface (decoded 8b/10b data plus K-flags, on gtp_clk) and the RX data FIFO write port.
- Acquires word alignment on IDLE, including byte-swap correction. Strips IDLEs, forwards data words, flags protocol errors, and optionally checks the incrementing test pattern.

Parameters:
- IDLE_WORD, 16'h50BC, IDLE pattern; low byte K28.5, high byte D16.2.
- ALIGN_CNT, 8, consecutive aligned IDLEs required to declare link up (range 2..255).
- LOSS_CNT, 4, consecutive bad words that drop the link back to alignment (range 1..255).
- CHECK_SEQ, 1, 1 enables the incrementing-pattern checker on data words.

Ports:
- gtp_clk, input, 1, RX user clock; all logic is on this clock.
- reset_n, input, 1, asynchronous active-low reset.
- rxinit_done, input, 1, GTP RX initialisation complete.
- rxdata, input, 16, decoded RX word; byte 0 = [7:0].
- rxcharisk, input, 2, per-byte K flag.
- fifo_full, input, 1, RX FIFO full.
- rx_data, output, 16, aligned data word.
- rx_valid, output, 1, FIFO write enable; one word per cycle.
- link_up, output, 1, high in state LINKED.
- swap, output, 1, 1 = byte-swapped alignment in use.
- err_cnt, output, 16, saturating count of protocol errors.
- seq_err_cnt, output, 16, saturating count of pattern mismatches.
- overflow, output, 1, sticky; a word was dropped because of fifo_full.

Behaviour:
- Reset (async assert, sync release): state DOWN. All outputs 0. Counters 0. Internal expected-sequence value 0 and invalid.
- Input pipeline:
  - Stage 1 registers rxdata/rxcharisk as cur, and the previous cur as prev.
  - Aligned word: {cur.data, cur.k} when swap=0; {cur[7:0], prev[15:8]} with K = {cur.k[0], prev.k[1]} when swap=1.
  - rx_data/rx_valid are registered from the aligned word. Latency from input to rx_valid is 2 cycles in both swap modes.
- Word classes, on the aligned word:
  - IDLE: data==IDLE_WORD and K==2'b01.
  - DATA: K==2'b00.
  - BAD: anything else.
- States:
  - DOWN: waits for rxinit_done=1, then goes to ALIGN with its counter cleared. rxinit_done=0 in any state forces DOWN on the next cycle; swap and counters are kept, link_up drops.
  - ALIGN:
    - Raw cur == IDLE_WORD with K 2'b01: treat as aligned; set swap=0 and increment the align counter.
    - {cur[7:0], prev[15:8]} == IDLE_WORD with K 2'b01: set swap=1 and increment.
    - Any other word clears the counter.
    - A change of swap value restarts the count at 1.
    - Counter reaching ALIGN_CNT moves to LINKED. No rx_valid is asserted in ALIGN.
  - LINKED:
    - IDLE: dropped; bad-run counter cleared.
    - DATA: rx_valid=1 unless fifo_full=1. When fifo_full=1 the word is dropped, overflow is set, and the sequence check still runs. Bad-run counter cleared.
    - BAD: dropped; err_cnt += 1 (saturates at 16'hFFFF); bad-run counter += 1. Reaching LOSS_CNT moves to ALIGN with link_up=0 and the align counter cleared.
- Sequence check (CHECK_SEQ=1):
  - The first DATA word after entering LINKED seeds expected = word + 1 with no check.
  - Each later DATA word: if word != expected, seq_err_cnt += 1 (saturating). expected = word + 1, mod 2^16, so 16'hFFFF followed by 16'h0000 is correct.
  - IDLEs between data words do not disturb expected.
  - Leaving LINKED invalidates expected.
- overflow clears only on reset_n.
- A BAD word and fifo_full in the same cycle: only err_cnt is affected; overflow is not set.

Test Plan:
- Reset and idle lock: hold reset_n=0, then release. Drive rxinit_done=1 with 16'h50BC/K 2'b01 continuously. Expect link_up=1 after 8 aligned IDLEs plus pipeline delay, swap=0, and no rx_valid.
- Swapped lock: drive the stream so IDLE arrives as 16'hBCxx/K 2'b10 halves across words. Expect swap=1, link_up=1, and data 16'h1234 sent in that skew output as rx_data=16'h1234.
- Pattern pass-through:
  - After lock, send data 0..999 with random IDLEs inserted. Expect 1000 rx_valid pulses carrying 0..999, seq_err_cnt=0, err_cnt=0.
  - Wrap case: 16'hFFFE, FFFF, 0000 gives seq_err_cnt=0.
  - Skip case: 5 followed by 7 gives seq_err_cnt=1.
- Errors and loss: in LINKED, inject 3 BAD words (K 2'b11), then IDLE. Expect err_cnt=3 and link_up still 1. Then inject 4 consecutive BAD words. Expect err_cnt=7, link_up=0, and relock after 8 IDLEs.
- Backpressure: hold fifo_full=1 during 5 data words. Expect no rx_valid, overflow=1 (sticky), and seq_err_cnt unchanged when the pattern resumes.
- Mid-operation reset: assert reset_n=0 mid-burst, or drop rxinit_done. Expect immediate all-zero outputs on reset, and link_up=0 on the next cycle after rxinit_done falls. Relock on IDLE reproduces the first scenario.

Source files
------------

// File: rtl/gtp_rx_deframer.sv
// GTP RX deframer: acquires IDLE word alignment (with byte-swap), strips IDLEs, forwards data
// words to the RX FIFO and tracks protocol and test-pattern errors.
module gtp_rx_deframer #(
    parameter logic [15:0] IDLE_WORD = 16'h50BC,
    parameter int unsigned ALIGN_CNT = 8,
    parameter int unsigned LOSS_CNT  = 4,
    parameter int unsigned CHECK_SEQ = 1
) (
    input  logic        gtp_clk,
    input  logic        reset_n,
    input  logic        rxinit_done,
    input  logic [15:0] rxdata,
    input  logic [1:0]  rxcharisk,
    input  logic        fifo_full,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        link_up,
    output logic        swap,
    output logic [15:0] err_cnt,
    output logic [15:0] seq_err_cnt,
    output logic        overflow
);

    typedef enum logic [1:0] {StDown, StAlign, StLinked} state_e;

    localparam logic [7:0] AlignCntW = 8'(ALIGN_CNT);
    localparam logic [7:0] LossCntW  = 8'(LOSS_CNT);

    state_e      state_q;
    logic [15:0] cur_data_q, prev_data_q;
    logic [1:0]  cur_k_q, prev_k_q;
    logic [7:0]  align_cnt_q, bad_cnt_q;
    logic [15:0] rx_data_q, err_cnt_q, seq_err_cnt_q, seq_exp_q;
    logic        rx_valid_q, link_up_q, swap_q, overflow_q, seq_vld_q;

    logic [15:0] swp_data, aln_data, err_inc, seq_err_inc;
    logic [1:0]  swp_k, aln_k;
    logic        is_idle, is_data, raw_idle, swp_idle;
    logic [7:0]  align_next, bad_inc;

    always_ff @(posedge gtp_clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_data_q  <= '0;
            cur_k_q     <= '0;
            prev_data_q <= '0;
            prev_k_q    <= '0;
        end else begin
            cur_data_q  <= rxdata;
            cur_k_q     <= rxcharisk;
            prev_data_q <= cur_data_q;
            prev_k_q    <= cur_k_q;
        end
    end

    always_comb begin
        swp_data    = {cur_data_q[7:0], prev_data_q[15:8]};
        swp_k       = {cur_k_q[0], prev_k_q[1]};
        aln_data    = swap_q ? swp_data : cur_data_q;
        aln_k       = swap_q ? swp_k : cur_k_q;
        is_idle     = (aln_data == IDLE_WORD) && (aln_k == 2'b01);
        is_data     = (aln_k == 2'b00);
        raw_idle    = (cur_data_q == IDLE_WORD) && (cur_k_q == 2'b01);
        swp_idle    = (swp_data == IDLE_WORD) && (swp_k == 2'b01);
        // A raw match wins; switching alignment restarts the run at one.
        align_next  = ((!raw_idle) != swap_q) ? 8'd1 : align_cnt_q + 8'd1;
        bad_inc     = bad_cnt_q + 8'd1;
        err_inc     = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
        seq_err_inc = (seq_err_cnt_q == 16'hFFFF) ? seq_err_cnt_q : seq_err_cnt_q + 16'd1;
    end

    always_ff @(posedge gtp_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StDown;
            align_cnt_q   <= '0;
            bad_cnt_q     <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            link_up_q     <= 1'b0;
            swap_q        <= 1'b0;
            err_cnt_q     <= '0;
            seq_err_cnt_q <= '0;
            seq_exp_q     <= '0;
            seq_vld_q     <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (!rxinit_done) begin
                state_q   <= StDown;
                link_up_q <= 1'b0;
                seq_vld_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StDown: begin
                        state_q     <= StAlign;
                        align_cnt_q <= '0;
                    end
                    StAlign: begin
                        if (raw_idle || swp_idle) begin
                            swap_q      <= !raw_idle;
                            align_cnt_q <= align_next;
                            if (align_next == AlignCntW) begin
                                state_q   <= StLinked;
                                link_up_q <= 1'b1;
                                bad_cnt_q <= '0;
                                seq_vld_q <= 1'b0;
                            end
                        end else begin
                            align_cnt_q <= '0;
                        end
                    end
                    StLinked: begin
                        if (is_idle) begin
                            bad_cnt_q <= '0;
                        end else if (is_data) begin
                            bad_cnt_q <= '0;
                            if (fifo_full) begin
                                overflow_q <= 1'b1;
                            end else begin
                                rx_valid_q <= 1'b1;
                                rx_data_q  <= aln_data;
                            end
                            if (CHECK_SEQ != 0) begin
                                if (seq_vld_q && (aln_data != seq_exp_q)) begin
                                    seq_err_cnt_q <= seq_err_inc;
                                end
                                seq_exp_q <= aln_data + 16'd1;
                                seq_vld_q <= 1'b1;
                            end
                        end else begin
                            err_cnt_q <= err_inc;
                            bad_cnt_q <= bad_inc;
                            if (bad_inc == LossCntW) begin
                                state_q     <= StAlign;
                                link_up_q   <= 1'b0;
                                align_cnt_q <= '0;
                                seq_vld_q   <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= StDown;
                endcase
            end
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign link_up     = link_up_q;
    assign swap        = swap_q;
    assign err_cnt     = err_cnt_q;
    assign seq_err_cnt = seq_err_cnt_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_gtp_rx_deframer.sv
// Scoreboard bench for gtp_rx_deframer: directed streams, queue of expected FIFO writes.
module tb_gtp_rx_deframer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rxinit_done = 1'b0;
    logic [15:0] rxdata = 16'h0000;
    logic [1:0]  rxcharisk = 2'b00;
    logic        fifo_full = 1'b0;
    logic [15:0] rx_data, err_cnt, seq_err_cnt;
    logic        rx_valid, link_up, swap, overflow;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    logic [15:0] sb[$];

    logic       skew = 1'b0;
    logic [7:0] hold_d = 8'h50;
    logic       hold_k = 1'b0;

    gtp_rx_deframer dut (
        .gtp_clk    (clk),
        .reset_n    (reset_n),
        .rxinit_done(rxinit_done),
        .rxdata     (rxdata),
        .rxcharisk  (rxcharisk),
        .fifo_full  (fifo_full),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .link_up    (link_up),
        .swap       (swap),
        .err_cnt    (err_cnt),
        .seq_err_cnt(seq_err_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every FIFO write must match the oldest expected word.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %0h expected none", rx_data);
            end else begin
                logic [15:0] exp;
                exp = sb.pop_front();
                pops++;
                if (rx_data !== exp) begin
                    errors++;
                    $display("FAIL rx_data: got %0h expected %0h", rx_data, exp);
                end
            end
        end
    end

    // In skew mode each logical word straddles two input words.
    task automatic drive(input logic [15:0] w, input logic [1:0] k);
        @(negedge clk);
        if (skew) begin
            rxdata    = {w[7:0], hold_d};
            rxcharisk = {k[0], hold_k};
            hold_d    = w[15:8];
            hold_k    = k[1];
        end else begin
            rxdata    = w;
            rxcharisk = k;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(16'h50BC, 2'b01);
    endtask

    task automatic send_data(input logic [15:0] w);
        if (!fifo_full) sb.push_back(w);
        drive(w, 2'b00);
    endtask

    task automatic bad(input int n);
        for (int i = 0; i < n; i++) drive(16'hDEAD, 2'b11);
    endtask

    task automatic wait_link(input int bound);
        for (int i = 0; i < bound && link_up !== 1'b1; i++) idle(1);
        check("link_up_relock", 32'(link_up), 32'd1);
    endtask

    task automatic release_and_lock();
        skew        = 1'b0;
        rxdata      = 16'h50BC;
        rxcharisk   = 2'b01;
        rxinit_done = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        idle(8);
        check("link_up_before_8", 32'(link_up), 32'd0);
        idle(1);
        check("link_up_after_8", 32'(link_up), 32'd1);
        check("swap_lock", 32'(swap), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        repeat (3) @(negedge clk);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_link_up", 32'(link_up), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        release_and_lock();

        // Wrap then incrementing pattern with random IDLE gaps.
        p0 = pops;
        send_data(16'hFFFE);
        send_data(16'hFFFF);
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send_data(16'(i));
        end
        idle(4);
        check("pattern_writes", 32'(pops - p0), 32'd1002);
        check("pattern_seq_err", 32'(seq_err_cnt), 32'd0);
        check("pattern_err", 32'(err_cnt), 32'd0);

        // Short bad run is tolerated; a run of four drops the link.
        bad(3);
        idle(3);
        check("bad3_err", 32'(err_cnt), 32'd3);
        check("bad3_link", 32'(link_up), 32'd1);
        bad(4);
        idle(2);
        check("bad4_err", 32'(err_cnt), 32'd7);
        check("bad4_link", 32'(link_up), 32'd0);
        idle(3);
        check("bad4_link_still_down", 32'(link_up), 32'd0);
        wait_link(20);

        // First word after relock only seeds the checker; 5 -> 7 is one skip.
        send_data(16'd5);
        send_data(16'd7);
        send_data(16'd8);
        idle(3);
        check("skip_seq_err", 32'(seq_err_cnt), 32'd1);

        // BAD under fifo_full counts an error but is not an overflow.
        fifo_full = 1'b1;
        bad(1);
        idle(3);
        check("bad_full_err", 32'(err_cnt), 32'd8);
        check("bad_full_ovf", 32'(overflow), 32'd0);
        for (int i = 9; i <= 13; i++) send_data(16'(i));
        idle(3);
        fifo_full = 1'b0;
        check("bp_overflow", 32'(overflow), 32'd1);
        send_data(16'd14);
        send_data(16'd15);
        idle(3);
        check("bp_seq_err", 32'(seq_err_cnt), 32'd1);
        check("bp_overflow_sticky", 32'(overflow), 32'd1);

        // Dropping rxinit_done takes the link down next cycle and keeps counters.
        @(negedge clk);
        rxinit_done = 1'b0;
        @(negedge clk);
        check("init_drop_link", 32'(link_up), 32'd0);
        check("init_drop_err_kept", 32'(err_cnt), 32'd8);

        // Relock on a byte-swapped IDLE stream.
        skew        = 1'b1;
        hold_d      = 8'h50;
        hold_k      = 1'b0;
        rxinit_done = 1'b1;
        wait_link(30);
        check("swap_mode", 32'(swap), 32'd1);
        p0 = pops;
        send_data(16'h1234);
        idle(4);
        check("swap_writes", 32'(pops - p0), 32'd1);

        // Asynchronous reset in the middle of a burst.
        send_data(16'h1235);
        send_data(16'h1236);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rx_valid), 32'd0);
        check("mid_rst_link", 32'(link_up), 32'd0);
        check("mid_rst_swap", 32'(swap), 32'd0);
        check("mid_rst_err", 32'(err_cnt), 32'd0);
        check("mid_rst_seq_err", 32'(seq_err_cnt), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_data", 32'(rx_data), 32'd0);
        sb.delete();
        @(negedge clk);
        release_and_lock();
        send_data(16'h00AA);
        idle(4);
        check("final_queue_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
